// File: rtl/rw_reg_bank.sv
// Mode-gated read/write register bank with a stored CRC per register and
// lockable entries; read responses and error pulses are registered (latency 1).
module rw_reg_bank #(
    parameter int unsigned               DW           = 8,
    parameter int unsigned               AW           = 8,
    parameter int unsigned               CRC_W        = 8,
    parameter int unsigned               NUM_REG      = 4,
    parameter int unsigned               BASE_ADDR    = 0,
    parameter logic [NUM_REG*DW-1:0]     DEFAULT_VAL  = '0,
    parameter logic [NUM_REG-1:0]        TEST_WR_MASK = '1,
    parameter logic [NUM_REG-1:0]        TEST_RD_MASK = '1,
    parameter logic [NUM_REG-1:0]        CFG_WR_MASK  = '1,
    parameter logic [NUM_REG-1:0]        CFG_RD_MASK  = '1,
    parameter logic [NUM_REG-1:0]        LOCK_MASK    = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_wen,
    input  logic                  i_ren,
    input  logic                  i_test_mode_status,
    input  logic                  i_cfg_mode_status,
    input  logic                  i_lock,
    input  logic [AW-1:0]         i_addr,
    input  logic [DW-1:0]         i_wdata,
    input  logic [CRC_W-1:0]      i_crc_data,
    output logic [DW-1:0]         o_rdata,
    output logic [CRC_W-1:0]      o_rcrc,
    output logic                  o_rvalid,
    output logic                  o_err,
    output logic [NUM_REG*DW-1:0] o_reg_data
);

    localparam int unsigned IDX_W = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;

    // One extra bit so BASE_ADDR+NUM_REG never wraps inside the address space.
    localparam logic [AW:0] BASE_X = (AW+1)'(BASE_ADDR);
    localparam logic [AW:0] END_X  = (AW+1)'(BASE_ADDR + NUM_REG);

    logic [DW-1:0]    regs [NUM_REG];
    logic [CRC_W-1:0] crcs [NUM_REG];

    logic [AW:0]      addr_x;
    logic [IDX_W-1:0] idx;
    logic             hit;
    logic             wr_ok;
    logic             rd_ok;

    always_comb begin
        addr_x = {1'b0, i_addr};
        hit    = (addr_x >= BASE_X) && (addr_x < END_X);
        idx    = IDX_W'(addr_x - BASE_X);
        wr_ok  = 1'b0;
        rd_ok  = 1'b0;
        if (hit) begin
            wr_ok = ((i_test_mode_status & TEST_WR_MASK[idx]) |
                     (i_cfg_mode_status  & CFG_WR_MASK[idx])) &
                    ~(i_lock & LOCK_MASK[idx]);
            rd_ok = (i_test_mode_status & TEST_RD_MASK[idx]) |
                    (i_cfg_mode_status  & CFG_RD_MASK[idx]);
        end
    end

    // Reads sample the pre-edge contents, so a same-cycle write is not visible.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < int'(NUM_REG); k++) begin
                regs[k] <= DEFAULT_VAL[k*DW +: DW];
                crcs[k] <= '0;
            end
            o_rdata  <= '0;
            o_rcrc   <= '0;
            o_rvalid <= 1'b0;
            o_err    <= 1'b0;
        end else begin
            o_rvalid <= i_ren;
            o_rdata  <= (i_ren && rd_ok) ? regs[idx] : '0;
            o_rcrc   <= (i_ren && rd_ok) ? crcs[idx] : '0;
            o_err    <= (i_wen && !wr_ok) || (i_ren && !rd_ok);
            if (i_wen && wr_ok) begin
                regs[idx] <= i_wdata;
                crcs[idx] <= i_crc_data;
            end
        end
    end

    for (genvar k = 0; k < int'(NUM_REG); k++) begin : g_pack
        assign o_reg_data[k*DW +: DW] = regs[k];
    end

endmodule

// File: tb/tb_rw_reg_bank.sv
// Directed bench for rw_reg_bank: base 0x10, four 8-bit registers, reg 1 lockable,
// reg 3 not writable and reg 0 not readable in test mode.
module tb_rw_reg_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wen = 1'b0;
    logic        ren = 1'b0;
    logic        tmode = 1'b0;
    logic        cmode = 1'b0;
    logic        lock = 1'b0;
    logic [7:0]  addr = '0;
    logic [7:0]  wdata = '0;
    logic [7:0]  crc = '0;
    logic [7:0]  rdata;
    logic [7:0]  rcrc;
    logic        rvalid;
    logic        err;
    logic [31:0] reg_data;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    rw_reg_bank #(
        .DW(8), .AW(8), .CRC_W(8), .NUM_REG(4), .BASE_ADDR(8'h10),
        .DEFAULT_VAL(32'h4433_2211),
        .TEST_WR_MASK(4'b0111), .TEST_RD_MASK(4'b1110),
        .CFG_WR_MASK(4'b1111), .CFG_RD_MASK(4'b1111),
        .LOCK_MASK(4'b0010)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wen(wen), .i_ren(ren),
        .i_test_mode_status(tmode), .i_cfg_mode_status(cmode), .i_lock(lock),
        .i_addr(addr), .i_wdata(wdata), .i_crc_data(crc),
        .o_rdata(rdata), .o_rcrc(rcrc), .o_rvalid(rvalid), .o_err(err),
        .o_reg_data(reg_data)
    );

    // One request cycle: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic cyc(input logic w, input logic r, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] c);
        @(negedge clk);
        wen = w; ren = r; addr = a; wdata = d; crc = c;
        @(posedge clk);
        #1;
        wen = 1'b0; ren = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (reg_data !== 32'h4433_2211) begin bad++; $display("FAIL reset_reg_data got=%h want=44332211", reg_data); end
        total++; if ({rvalid, err, rdata, rcrc} !== 18'h0) begin bad++; $display("FAIL reset_outputs got rv=%b err=%b rd=%h rc=%h want all 0", rvalid, err, rdata, rcrc); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read;
        cmode = 1'b1; tmode = 1'b0;
        cyc(1, 0, 8'h12, 8'hA5, 8'h3C);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL wr_err got=%b want=0", err); end
        total++; if (reg_data !== 32'h44A5_2211) begin bad++; $display("FAIL wr_reg_data got=%h want=44a52211", reg_data); end
        cyc(0, 1, 8'h12, 8'h00, 8'h00);
        total++; if ({rvalid, err, rdata, rcrc} !== {1'b1, 1'b0, 8'hA5, 8'h3C}) begin bad++; $display("FAIL rd_resp got rv=%b err=%b rd=%h rc=%h want rv=1 err=0 rd=a5 rc=3c", rvalid, err, rdata, rcrc); end
        cyc(0, 0, 8'h12, 8'h00, 8'h00);
        total++; if ({rvalid, err, rdata, rcrc} !== 18'h0) begin bad++; $display("FAIL idle_outputs got rv=%b err=%b rd=%h rc=%h want all 0", rvalid, err, rdata, rcrc); end
        cyc(0, 1, 8'h10, 8'h00, 8'h00);
        total++; if ({rvalid, rdata, rcrc} !== {1'b1, 8'h11, 8'h00}) begin bad++; $display("FAIL rd_reset_crc got rv=%b rd=%h rc=%h want rv=1 rd=11 rc=00", rvalid, rdata, rcrc); end
    endtask

    task automatic test_miss;
        cyc(1, 0, 8'h14, 8'h99, 8'h01);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL miss_wr_err got=%b want=1", err); end
        total++; if (reg_data !== 32'h44A5_2211) begin bad++; $display("FAIL miss_wr_data got=%h want=44a52211", reg_data); end
        cyc(0, 0, 8'h14, 8'h00, 8'h00);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL err_pulse_width got=%b want=0", err); end
        cyc(0, 1, 8'h14, 8'h00, 8'h00);
        total++; if ({rvalid, err, rdata, rcrc} !== {1'b1, 1'b1, 8'h00, 8'h00}) begin bad++; $display("FAIL miss_rd_hi got rv=%b err=%b rd=%h rc=%h want rv=1 err=1 rd=0 rc=0", rvalid, err, rdata, rcrc); end
        cyc(0, 1, 8'h0F, 8'h00, 8'h00);
        total++; if ({rvalid, err, rdata} !== {1'b1, 1'b1, 8'h00}) begin bad++; $display("FAIL miss_rd_lo got rv=%b err=%b rd=%h want rv=1 err=1 rd=0", rvalid, err, rdata); end
        cyc(0, 1, 8'h13, 8'h00, 8'h00);
        total++; if ({rvalid, err, rdata} !== {1'b1, 1'b0, 8'h44}) begin bad++; $display("FAIL top_reg_rd got rv=%b err=%b rd=%h want rv=1 err=0 rd=44", rvalid, err, rdata); end
    endtask

    task automatic test_lock;
        lock = 1'b1;
        cyc(1, 0, 8'h11, 8'h77, 8'h07);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL locked_wr_err got=%b want=1", err); end
        total++; if (reg_data !== 32'h44A5_2211) begin bad++; $display("FAIL locked_wr_data got=%h want=44a52211", reg_data); end
        cyc(1, 0, 8'h12, 8'h66, 8'h06);
        total++; if ({err, reg_data} !== {1'b0, 32'h4466_2211}) begin bad++; $display("FAIL unlockable_wr got err=%b data=%h want err=0 data=44662211", err, reg_data); end
        lock = 1'b0;
        cyc(1, 0, 8'h11, 8'h77, 8'h07);
        total++; if ({err, reg_data} !== {1'b0, 32'h4466_7711}) begin bad++; $display("FAIL unlocked_wr got err=%b data=%h want err=0 data=44667711", err, reg_data); end
    endtask

    task automatic test_same_cycle;
        cyc(1, 1, 8'h10, 8'h55, 8'h5A);
        total++; if ({rvalid, err, rdata, rcrc} !== {1'b1, 1'b0, 8'h11, 8'h00}) begin bad++; $display("FAIL rw_same_old got rv=%b err=%b rd=%h rc=%h want rv=1 err=0 rd=11 rc=00", rvalid, err, rdata, rcrc); end
        cyc(0, 1, 8'h10, 8'h00, 8'h00);
        total++; if ({rdata, rcrc} !== {8'h55, 8'h5A}) begin bad++; $display("FAIL rw_same_new got rd=%h rc=%h want rd=55 rc=5a", rdata, rcrc); end
        total++; if (reg_data !== 32'h4466_7755) begin bad++; $display("FAIL rw_same_data got=%h want=44667755", reg_data); end
    endtask

    task automatic test_modes;
        cmode = 1'b0; tmode = 1'b1;
        cyc(1, 0, 8'h13, 8'h88, 8'h08);
        total++; if ({err, reg_data} !== {1'b1, 32'h4466_7755}) begin bad++; $display("FAIL test_wr_denied got err=%b data=%h want err=1 data=44667755", err, reg_data); end
        cyc(1, 0, 8'h10, 8'h01, 8'h00);
        total++; if ({err, reg_data} !== {1'b0, 32'h4466_7701}) begin bad++; $display("FAIL test_wr_ok got err=%b data=%h want err=0 data=44667701", err, reg_data); end
        cyc(0, 1, 8'h10, 8'h00, 8'h00);
        total++; if ({rvalid, err, rdata} !== {1'b1, 1'b1, 8'h00}) begin bad++; $display("FAIL test_rd_denied got rv=%b err=%b rd=%h want rv=1 err=1 rd=0", rvalid, err, rdata); end
        cyc(0, 1, 8'h11, 8'h00, 8'h00);
        total++; if ({rvalid, err, rdata, rcrc} !== {1'b1, 1'b0, 8'h77, 8'h07}) begin bad++; $display("FAIL test_rd_ok got rv=%b err=%b rd=%h rc=%h want rv=1 err=0 rd=77 rc=07", rvalid, err, rdata, rcrc); end
        cyc(1, 1, 8'h10, 8'h02, 8'h00);
        total++; if ({rvalid, err, rdata, reg_data} !== {1'b1, 1'b1, 8'h00, 32'h4466_7702}) begin bad++; $display("FAIL err_or got rv=%b err=%b rd=%h data=%h want rv=1 err=1 rd=0 data=44667702", rvalid, err, rdata, reg_data); end
        tmode = 1'b0;
        cyc(0, 1, 8'h11, 8'h00, 8'h00);
        total++; if ({rvalid, err, rdata} !== {1'b1, 1'b1, 8'h00}) begin bad++; $display("FAIL no_mode_rd got rv=%b err=%b rd=%h want rv=1 err=1 rd=0", rvalid, err, rdata); end
        cyc(1, 0, 8'h11, 8'hEE, 8'h00);
        total++; if ({err, reg_data} !== {1'b1, 32'h4466_7702}) begin bad++; $display("FAIL no_mode_wr got err=%b data=%h want err=1 data=44667702", err, reg_data); end
        tmode = 1'b1; cmode = 1'b1;
        cyc(1, 0, 8'h13, 8'h99, 8'h09);
        total++; if ({err, reg_data} !== {1'b0, 32'h9966_7702}) begin bad++; $display("FAIL both_mode_wr got err=%b data=%h want err=0 data=99667702", err, reg_data); end
        cyc(0, 1, 8'h10, 8'h00, 8'h00);
        total++; if ({rvalid, err, rdata} !== {1'b1, 1'b0, 8'h02}) begin bad++; $display("FAIL both_mode_rd got rv=%b err=%b rd=%h want rv=1 err=0 rd=02", rvalid, err, rdata); end
        tmode = 1'b0;
    endtask

    task automatic test_back_to_back;
        cyc(1, 0, 8'h11, 8'hB1, 8'h0B);
        total++; if ({err, reg_data} !== {1'b0, 32'h9966_B102}) begin bad++; $display("FAIL b2b_wr got err=%b data=%h want err=0 data=9966b102", err, reg_data); end
        cyc(0, 1, 8'h11, 8'h00, 8'h00);
        total++; if ({rvalid, rdata, rcrc} !== {1'b1, 8'hB1, 8'h0B}) begin bad++; $display("FAIL b2b_rd1 got rv=%b rd=%h rc=%h want rv=1 rd=b1 rc=0b", rvalid, rdata, rcrc); end
        cyc(0, 1, 8'h12, 8'h00, 8'h00);
        total++; if ({rvalid, rdata, rcrc} !== {1'b1, 8'h66, 8'h06}) begin bad++; $display("FAIL b2b_rd2 got rv=%b rd=%h rc=%h want rv=1 rd=66 rc=06", rvalid, rdata, rcrc); end
        cyc(0, 1, 8'h13, 8'h00, 8'h00);
        total++; if ({rvalid, rdata, rcrc} !== {1'b1, 8'h99, 8'h09}) begin bad++; $display("FAIL b2b_rd3 got rv=%b rd=%h rc=%h want rv=1 rd=99 rc=09", rvalid, rdata, rcrc); end
    endtask

    task automatic test_reset_mid_read;
        // Reset lands during a live response: outputs clear without waiting for a clock.
        cyc(0, 1, 8'h11, 8'h00, 8'h00);
        #1 rst_n = 1'b0;
        #1;
        total++; if ({rvalid, rdata, rcrc} !== 17'h0) begin bad++; $display("FAIL async_clear got rv=%b rd=%h rc=%h want all 0", rvalid, rdata, rcrc); end
        @(negedge clk);
        rst_n = 1'b1;
        // Request pending while reset asserts is dropped.
        @(negedge clk);
        ren = 1'b1; addr = 8'h11;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL mid_read_rvalid got=%b want=0", rvalid); end
        ren = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if ({rvalid, err} !== 2'b00) begin bad++; $display("FAIL post_reset_resp got rv=%b err=%b want 0 0", rvalid, err); end
        total++; if (reg_data !== 32'h4433_2211) begin bad++; $display("FAIL post_reset_data got=%h want=44332211", reg_data); end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_miss;
        test_lock;
        test_same_cycle;
        test_modes;
        test_back_to_back;
        test_reset_mid_read;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
